// File: rtl/text_buffer.sv
// text_buffer: ROWS x COLS character grid with a cursor, driven by key-decoder
// strobes. After reset a sweep fills every cell with spaces. After that, at most
// one key event is applied per cycle. A registered read port serves the renderer.
module text_buffer #(
    parameter int COL_BITS = 4,
    parameter int ROW_BITS = 1,
    parameter int ROWS     = 2
) (
    input  logic                clk,
    input  logic                i_sclr,
    input  logic                i_en,
    input  logic [7:0]          i_ascii,
    input  logic                i_ascii_en,
    input  logic                i_right_en,
    input  logic                i_down_en,
    input  logic                i_left_en,
    input  logic [ROW_BITS-1:0] i_rd_row,
    input  logic [COL_BITS-1:0] i_rd_col,
    output logic [7:0]          o_rd_char,
    output logic [ROW_BITS-1:0] o_cur_row,
    output logic [COL_BITS-1:0] o_cur_col,
    output logic                o_busy,
    output logic                o_upd
);

    localparam int                 AW       = ROW_BITS + COL_BITS;
    localparam int                 DEPTH    = 2 ** AW;
    localparam logic [AW-1:0]      CLR_LAST = AW'(ROWS * (2 ** COL_BITS) - 1);
    localparam logic [COL_BITS-1:0] COL_MAX = '1;
    localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(ROWS - 1);
    localparam logic [7:0]         CH_BS    = 8'h08;
    localparam logic [7:0]         CH_SP    = 8'h20;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_clr_addr;
    logic [ROW_BITS-1:0] r_cur_row;
    logic [COL_BITS-1:0] r_cur_col;
    logic                r_busy;
    logic                r_upd;
    logic [7:0]          r_rd_char;
    logic [7:0]          r_mem [DEPTH];

    logic                w_we;
    logic [AW-1:0]       w_waddr;
    logic [7:0]          w_wdata;
    logic [ROW_BITS-1:0] w_nxt_row;
    logic [COL_BITS-1:0] w_nxt_col;
    logic                w_evt;

    // Decode the single highest-priority key event into a write and a new cursor.
    always_comb begin
        w_we      = 1'b0;
        w_waddr   = {r_cur_row, r_cur_col};
        w_wdata   = CH_SP;
        w_nxt_row = r_cur_row;
        w_nxt_col = r_cur_col;
        w_evt     = 1'b0;
        if (r_state == S_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
        end else if (i_en) begin
            if (i_ascii_en) begin
                if (i_ascii == CH_BS) begin
                    if (r_cur_col != '0) begin
                        w_nxt_col = r_cur_col - COL_BITS'(1);
                        w_we      = 1'b1;
                        w_waddr   = {r_cur_row, r_cur_col - COL_BITS'(1)};
                        w_evt     = 1'b1;
                    end else if (r_cur_row != '0) begin
                        w_nxt_row = r_cur_row - ROW_BITS'(1);
                        w_nxt_col = COL_MAX;
                        w_we      = 1'b1;
                        w_waddr   = {r_cur_row - ROW_BITS'(1), COL_MAX};
                        w_evt     = 1'b1;
                    end
                end else begin
                    w_we    = 1'b1;
                    w_wdata = i_ascii;
                    w_evt   = 1'b1;
                    if (r_cur_col == COL_MAX) begin
                        w_nxt_col = '0;
                        w_nxt_row = (r_cur_row == ROW_MAX) ? '0 : r_cur_row + ROW_BITS'(1);
                    end else begin
                        w_nxt_col = r_cur_col + COL_BITS'(1);
                    end
                end
            end else if (i_left_en) begin
                if (r_cur_col != '0) begin
                    w_nxt_col = r_cur_col - COL_BITS'(1);
                    w_evt     = 1'b1;
                end
            end else if (i_right_en) begin
                if (r_cur_col != COL_MAX) begin
                    w_nxt_col = r_cur_col + COL_BITS'(1);
                    w_evt     = 1'b1;
                end
            end else if (i_down_en) begin
                if (ROWS > 1) begin
                    w_nxt_row = (r_cur_row == ROW_MAX) ? '0 : r_cur_row + ROW_BITS'(1);
                    w_evt     = 1'b1;
                end
            end
        end
        // A clear request overrides whatever the current state would write.
        if (i_sclr) begin
            w_we = 1'b0;
        end
    end

    // Control FSM: clear sweep, then event handling with registered status outputs.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_cur_row  <= '0;
            r_cur_col  <= '0;
            r_busy     <= 1'b1;
            r_upd      <= 1'b0;
        end else begin
            // Busy lags the state by one edge so it drops exactly when events start.
            r_busy <= (r_state == S_CLEAR);
            r_upd  <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + AW'(1);
                    if (r_clr_addr == CLR_LAST) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    r_cur_row <= w_nxt_row;
                    r_cur_col <= w_nxt_col;
                    r_upd     <= w_evt;
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    // Character storage; no reset so it can map onto a RAM.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Registered read port; a same-cycle write is not forwarded (old data returned).
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_rd_char <= 8'h00;
        end else begin
            r_rd_char <= r_mem[{i_rd_row, i_rd_col}];
        end
    end

    assign o_rd_char = r_rd_char;
    assign o_cur_row = r_cur_row;
    assign o_cur_col = r_cur_col;
    assign o_busy    = r_busy;
    assign o_upd     = r_upd;

endmodule

// File: doc/text_buffer.md
# text_buffer

Character-grid line editor directly downstream of the key decoder. It consumes the decoder's one-cycle strobes: an ASCII character or backspace (0x08), plus right, down and left cursor moves. It maintains a ROWS×COLS character memory and a cursor, and exposes a registered random-access read port plus the cursor position for the display/renderer stage.

## Interface
- COL_BITS, 4, column index width; COLS = 2**COL_BITS (default 16)
- ROW_BITS, 1, row index width
- ROWS, 2, number of rows, 1 ≤ ROWS ≤ 2**ROW_BITS
- clk  in  1  system clock, all logic on rising edge
- i_sclr  in  1  synchronous active-high reset/clear
- i_en  in  1  event enable; when 0 all key strobes are ignored (read port still operates)
- i_ascii  in  8  character code from decoder; 0x08 = backspace
- i_ascii_en  in  1  one-cycle strobe qualifying i_ascii
- i_right_en, i_down_en, i_left_en  in  1 each  one-cycle cursor-move strobes
- i_rd_row  in  ROW_BITS  display read row
- i_rd_col  in  COL_BITS  display read column
- o_rd_char  out  8  registered memory contents at {i_rd_row,i_rd_col}
- o_cur_row  out  ROW_BITS  cursor row
- o_cur_col  out  COL_BITS  cursor column
- o_busy  out  1  high while the post-reset clear sweep runs
- o_upd  out  1  one-cycle pulse: buffer or cursor changed

## Operation
- Memory: ROWS*COLS bytes, address {row,col}. Rows ≥ ROWS are never written.
- FSM states: CLEAR, IDLE.
  - CLEAR writes 0x20 to one address per cycle, 0 .. ROWS*COLS-1. All events are ignored.
  - CLEAR → IDLE after the last write.
- i_sclr (any state, including mid-sweep):
  - state ← CLEAR, sweep address ← 0, cursor ← (0,0).
  - o_busy ← 1, o_upd ← 0, o_rd_char ← 0x00.
  - The sweep restarts from 0.
- IDLE handles at most one event per cycle, only when i_en=1. Priority: ascii_en > left > right > down. Lower-priority strobes in the same cycle are dropped, not queued.
- Character (i_ascii ≠ 0x08):
  - Write i_ascii at the cursor.
  - Cursor advances col+1. At col COLS-1 it goes to col 0 of row+1. At (ROWS-1, COLS-1) it wraps to (0,0).
- Backspace (0x08):
  - col>0: col−1, write 0x20 at the new position.
  - col=0 and row>0: go to (row−1, COLS-1), write 0x20 there.
  - (0,0): no write, no move, no o_upd.
- Left: col−1, saturating at 0. Right: col+1, saturating at COLS-1. Neither wraps rows. A saturated no-op produces no o_upd.
- Down: row+1 modulo ROWS, column unchanged. When ROWS=1 it is a no-op with no o_upd.
- Any other ASCII code, including control codes, is stored literally.
- Read port:
  - o_rd_char ← mem[{i_rd_row,i_rd_col}] every cycle, in every state.
  - A write to the same address in the same cycle returns the old data (read-before-write).

## Timing
- Event strobe sampled at edge t. Memory write and cursor update take effect at edge t; o_cur_* shows the new value from t+1.
- o_upd is high for exactly the one cycle following an effective event, never during CLEAR.
- Read latency: 1 cycle from address to o_rd_char.
- Clear sweep:
  - i_sclr is deasserted before edge 0; sweep writes occur at edges 0 .. ROWS*COLS-1.
  - o_busy falls at edge ROWS*COLS.
  - The first accepted event is at edge ROWS*COLS.
- Back-to-back events on consecutive cycles are all accepted. No internal backpressure exists; the upstream decoder never stalls.
- Reset values: o_cur_row=0, o_cur_col=0, o_busy=1, o_upd=0, o_rd_char=0x00.

## Test plan
- **Reset clear:** pulse i_sclr, wait 32 cycles (defaults), read all 32 cells → every cell 0x20; o_busy low from cycle 32; cursor (0,0).
- **Type and wrap:**
  - Send 0x41 seventeen times → cells (0,0)..(1,0) hold 0x41; cursor (1,1); 17 o_upd pulses.
  - Continue to 32 characters total → cursor wraps to (0,0).
- **Backspace:**
  - At (1,0): backspace → cursor (0,15), cell (0,15)=0x20.
  - At (0,0): backspace → no change, no o_upd.
- **Cursor moves:**
  - Left at col 0 → stays, no o_upd.
  - Right at col 15 → stays.
  - Down at (1,5) → (0,5).
- **Simultaneous events and i_en:**
  - ascii_en+left+down in the same cycle → only the character is written and the cursor advances by 1.
  - Same strobes with i_en=0 → no change.
- **Reset mid-operation:**
  - Assert i_sclr at sweep cycle 10 → sweep restarts; o_busy stays high 32 more cycles; strobes during the sweep are ignored.
  - Read-before-write: read (0,0) while writing it returns the old value.
